// File: rtl/ntt_pkg.sv
// Shared NTT definitions: Kyber modulus, default widths/latency, coefficient type and
// modular add/sub helpers for the butterfly and the other NTT stages.
package ntt_pkg;

    localparam int DW      = 12;
    localparam int Q       = 3329;
    localparam int MUL_LAT = 5;

    typedef logic [DW-1:0] coef_t;

    typedef enum logic {
        MODE_CT = 1'b0,
        MODE_GS = 1'b1
    } bfly_mode_e;

    // One conditional subtract is enough because both operands are already below Q.
    function automatic coef_t mod_add(coef_t a, coef_t b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (DW+1)'(Q)) s = s - (DW+1)'(Q);
        return s[DW-1:0];
    endfunction

    function automatic coef_t mod_sub(coef_t a, coef_t b);
        logic signed [DW+1:0] d;
        d = $signed({2'b00, a}) - $signed({2'b00, b});
        if (d < 0) d = d + $signed((DW+2)'(Q));
        return d[DW-1:0];
    endfunction

endpackage

// File: rtl/ntt_butterfly_stage_if.sv
// Butterfly stage bus: coefficient read side, multiplier side and write-back side.
// Also counts illegal (>= Q) coefficients offered with in_valid.
interface ntt_butterfly_stage_if
    import ntt_pkg::*;
#(
    parameter int DW = ntt_pkg::DW,
    parameter int Q  = ntt_pkg::Q
) (
    input logic clk,
    input logic rst
);

    logic          in_valid;
    logic          in_mode;
    logic [DW-1:0] u;
    logic [DW-1:0] v;
    logic [DW-1:0] w;
    logic          mul_sel;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic [DW-1:0] mul_p;
    logic          out_valid;
    logic [DW-1:0] x;
    logic [DW-1:0] y;

    logic [15:0]   illegal_cnt;

    localparam logic [DW-1:0] QC = DW'(Q);

    // Simulation-only guard: coefficients must be reduced before they reach the butterfly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else begin
            assert (!(in_valid && (u >= QC || v >= QC || w >= QC)))
            else illegal_cnt <= illegal_cnt + 16'd1;
        end
    end

    modport master (
        output in_valid, in_mode, u, v, w, mul_p,
        input  mul_sel, mul_a, mul_b, out_valid, x, y
    );

    modport slave (
        input  in_valid, in_mode, u, v, w, mul_p,
        output mul_sel, mul_a, mul_b, out_valid, x, y
    );

endinterface

// File: rtl/mod_addsub.sv
// Combinational modular adder/subtractor: sum = (a+b) mod Q, diff = (a-b) mod Q.
module mod_addsub #(
    parameter int DW = ntt_pkg::DW,
    parameter int Q  = ntt_pkg::Q
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum,
    output logic [DW-1:0] diff
);

    function automatic logic [DW-1:0] add_mod(logic [DW-1:0] p, logic [DW-1:0] r);
        logic [DW:0] s;
        s = {1'b0, p} + {1'b0, r};
        if (s >= (DW+1)'(Q)) s = s - (DW+1)'(Q);
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sub_mod(logic [DW-1:0] p, logic [DW-1:0] r);
        logic signed [DW+1:0] d;
        d = $signed({2'b00, p}) - $signed({2'b00, r});
        if (d < 0) d = d + $signed((DW+2)'(Q));
        return d[DW-1:0];
    endfunction

    assign sum  = add_mod(a, b);
    assign diff = sub_mod(a, b);

endmodule

// File: rtl/ntt_butterfly_stage.sv
// Radix-2 Kyber butterfly (CT forward / GS inverse per item) around an external
// fixed-latency modular multiplier; fixed latency MUL_LAT + 2, one pair per cycle.
module ntt_butterfly_stage
    import ntt_pkg::*;
#(
    parameter int DW      = ntt_pkg::DW,
    parameter int Q       = ntt_pkg::Q,
    parameter int MUL_LAT = ntt_pkg::MUL_LAT
) (
    input logic                  clk,
    input logic                  rst,
    ntt_butterfly_stage_if.slave bus
);

    localparam int CW = DW + 2;

    logic [DW-1:0] s0_sum, s0_diff;
    logic [DW-1:0] mul_a_q, mul_a_d;
    logic [DW-1:0] mul_b_q, mul_b_d;
    logic [DW-1:0] carry_p0_q, carry_p0_d;
    logic          vld_p0_q, vld_p0_d;
    logic          mode_p0_q, mode_p0_d;

    logic [CW-1:0] dly_q [MUL_LAT];
    logic [CW-1:0] dly_d [MUL_LAT];

    logic          vld_al, mode_al;
    logic [DW-1:0] carry_al;
    logic [DW-1:0] fin_sum, fin_diff;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] x_q, x_d;
    logic [DW-1:0] y_q, y_d;

    // Stage 0: operands to the multiplier, plus the value that bypasses it
    mod_addsub #(.DW(DW), .Q(Q)) u_stage0_gs (
        .a    (bus.u),
        .b    (bus.v),
        .sum  (s0_sum),
        .diff (s0_diff)
    );

    always_comb begin
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        carry_p0_d = carry_p0_q;
        mode_p0_d  = mode_p0_q;
        vld_p0_d   = bus.in_valid;
        if (bus.in_valid) begin
            mode_p0_d = bus.in_mode;
            mul_b_d   = bus.w;
            if (bus.in_mode == MODE_GS) begin
                mul_a_d    = s0_diff;
                carry_p0_d = s0_sum;
            end else begin
                mul_a_d    = bus.v;
                carry_p0_d = bus.u;
            end
        end
    end

    // Delay line: {valid, mode, carried value} shifted to meet mul_p
    always_comb begin
        dly_d[0] = {vld_p0_q, mode_p0_q, carry_p0_q};
        for (int i = 1; i < MUL_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    assign {vld_al, mode_al, carry_al} = dly_q[MUL_LAT-1];

    // Final stage: combine the carried value with the product
    mod_addsub #(.DW(DW), .Q(Q)) u_final_ct (
        .a    (carry_al),
        .b    (bus.mul_p),
        .sum  (fin_sum),
        .diff (fin_diff)
    );

    always_comb begin
        out_valid_d = vld_al;
        x_d         = x_q;
        y_d         = y_q;
        if (vld_al) begin
            if (mode_al == MODE_GS) begin
                x_d = carry_al;
                y_d = bus.mul_p;
            end else begin
                x_d = fin_sum;
                y_d = fin_diff;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            carry_p0_q  <= '0;
            vld_p0_q    <= 1'b0;
            mode_p0_q   <= 1'b0;
            for (int i = 0; i < MUL_LAT; i++) begin
                dly_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            carry_p0_q  <= carry_p0_d;
            vld_p0_q    <= vld_p0_d;
            mode_p0_q   <= mode_p0_d;
            for (int i = 0; i < MUL_LAT; i++) begin
                dly_q[i] <= dly_d[i];
            end
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    assign bus.mul_sel   = 1'b1;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;

endmodule

// File: tb/tb_ntt_butterfly_stage.sv
// Bench for ntt_butterfly_stage: behavioural Barrett multiplier, per-cycle scoreboard of
// out_valid/x/y against a plain-arithmetic butterfly model, directed and random items.
module tb_ntt_butterfly_stage;

    localparam int DW   = 12;
    localparam int QM   = 3329;
    localparam int ML   = 5;
    localparam int LAT  = ML + 2;
    localparam int NCYC = 1024;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ntt_butterfly_stage_if #(.DW(DW), .Q(QM)) bfly_if (.clk(clk), .rst(rst));

    ntt_butterfly_stage #(.DW(DW), .Q(QM), .MUL_LAT(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bfly_if)
    );

    // Multiplier model: (mul_a*mul_b) mod Q appears MUL_LAT cycles after the operands
    logic [DW-1:0] mr [ML];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ML; i++) mr[i] <= '0;
        end else begin
            mr[0] <= DW'((int'(bfly_if.mul_a) * int'(bfly_if.mul_b)) % QM);
            for (int i = 1; i < ML; i++) mr[i] <= mr[i-1];
        end
    end
    assign bfly_if.mul_p = mr[ML-1];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit exp_v  [NCYC];
    bit exp_dc [NCYC];
    int exp_x  [NCYC];
    int exp_y  [NCYC];
    int hold_x, hold_y;
    bit hold_known;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d got %0d expected %0d", tag, cyc, got, expv);
        end
    endtask

    task automatic ref_bfly(input int mode, input int u, input int v, input int w,
                            output int x, output int y);
        int p;
        if (mode == 0) begin
            p = (v * w) % QM;
            x = (u + p) % QM;
            y = (u - p + QM) % QM;
        end else begin
            x = (u + v) % QM;
            y = (((u - v + QM) % QM) * w) % QM;
        end
    endtask

    task automatic sample();
        chk("out_valid", bfly_if.out_valid, exp_v[cyc]);
        if (exp_v[cyc] && !exp_dc[cyc]) begin
            hold_x     = exp_x[cyc];
            hold_y     = exp_y[cyc];
            hold_known = 1'b1;
        end else if (exp_v[cyc]) begin
            hold_known = 1'b0;
        end
        if (hold_known) begin
            chk("x", bfly_if.x, hold_x);
            chk("y", bfly_if.y, hold_y);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        sample();
    endtask

    task automatic bubble();
        bfly_if.in_valid = 1'b0;
        tick();
    endtask

    task automatic drive(input int mode, input int u, input int v, input int w, input bit dc);
        int ex, ey;
        bfly_if.in_valid = 1'b1;
        bfly_if.in_mode  = mode[0];
        bfly_if.u        = DW'(u);
        bfly_if.v        = DW'(v);
        bfly_if.w        = DW'(w);
        if (!dc) ref_bfly(mode, u, v, w, ex, ey);
        else begin
            ex = 0;
            ey = 0;
        end
        if (cyc + LAT < NCYC) begin
            exp_v [cyc + LAT] = 1'b1;
            exp_dc[cyc + LAT] = dc;
            exp_x [cyc + LAT] = ex;
            exp_y [cyc + LAT] = ey;
        end
        tick();
        bfly_if.in_valid = 1'b0;
        if (!dc) begin
            chk("mul_b", bfly_if.mul_b, w);
            chk("mul_a", bfly_if.mul_a, (mode == 0) ? v : (u - v + QM) % QM);
        end
    endtask

    task automatic run_one(input string tag, input int mode, input int u, input int v,
                           input int w, input int ex, input int ey);
        drive(mode, u, v, w, 1'b0);
        repeat (LAT - 1) tick();
        chk({tag, "_valid"}, bfly_if.out_valid, 1);
        chk({tag, "_x"}, bfly_if.x, ex);
        chk({tag, "_y"}, bfly_if.y, ey);
    endtask

    initial begin
        int cnt0;
        rst              = 1'b1;
        bfly_if.in_valid = 1'b0;
        bfly_if.in_mode  = 1'b0;
        bfly_if.u        = '0;
        bfly_if.v        = '0;
        bfly_if.w        = '0;
        hold_x           = 0;
        hold_y           = 0;
        hold_known       = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bfly_if.out_valid, 0);
        chk("rst_x", bfly_if.x, 0);
        chk("rst_y", bfly_if.y, 0);
        chk("rst_mul_a", bfly_if.mul_a, 0);
        chk("rst_mul_b", bfly_if.mul_b, 0);
        chk("mul_sel", bfly_if.mul_sel, 1);
        rst = 1'b0;
        cyc = 0;
        bubble();

        run_one("ct_basic", 0, 1, 1, 17, 18, 3313);
        run_one("ct_wrap_hi", 0, 3328, 1, 1, 0, 3327);
        run_one("ct_wrap_lo", 0, 0, 3328, 1, 3328, 1);
        run_one("gs_basic", 1, 5, 3, 2, 8, 4);
        run_one("gs_neg", 1, 3, 5, 1, 8, 3327);
        run_one("gs_max_sum", 1, 3328, 3328, 5, 3327, 0);

        // Alternating modes back to back
        drive(0, 100, 200, 300, 1'b0);
        drive(1, 100, 200, 300, 1'b0);
        drive(0, 3328, 3328, 3328, 1'b0);
        drive(1, 0, 3328, 3328, 1'b0);
        repeat (LAT) bubble();

        for (int n = 0; n < 64; n++) begin
            if ($urandom_range(0, 4) == 0) bubble();
            drive(int'($urandom_range(0, 1)), int'($urandom_range(0, QM - 1)),
                  int'($urandom_range(0, QM - 1)), int'($urandom_range(0, QM - 1)), 1'b0);
        end
        repeat (LAT + 1) bubble();

        // Reset with four items in flight
        for (int n = 0; n < 4; n++) begin
            drive(int'($urandom_range(0, 1)), int'($urandom_range(1, QM - 1)),
                  int'($urandom_range(0, QM - 1)), int'($urandom_range(1, QM - 1)), 1'b0);
        end
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bfly_if.out_valid, 0);
        chk("midrst_x", bfly_if.x, 0);
        chk("midrst_y", bfly_if.y, 0);
        for (int i = cyc; i < NCYC; i++) begin
            exp_v[i]  = 1'b0;
            exp_dc[i] = 1'b0;
        end
        hold_x     = 0;
        hold_y     = 0;
        hold_known = 1'b1;
        repeat (2) bubble();
        rst = 1'b0;
        repeat (LAT + 3) bubble();
        run_one("post_rst", 0, 7, 9, 11, 106, 3237);

        // Illegal coefficient with and without in_valid
        cnt0 = int'(bfly_if.illegal_cnt);
        drive(0, 3329, 1, 1, 1'b1);
        chk("illegal_fires", bfly_if.illegal_cnt, cnt0 + 1);
        bfly_if.u = DW'(3329);
        bubble();
        chk("illegal_silent", bfly_if.illegal_cnt, cnt0 + 1);
        bfly_if.u = '0;
        repeat (LAT + 1) bubble();
        run_one("after_illegal", 1, 10, 4, 3, 14, 18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
